imem_boot_loader: RTL and testbench

//  Write-side counterpart of the 256-word instruction ROM: receives a program image as a byte

---
 rtl/imem_boot_loader_pkg.sv | 29 ++
 rtl/imem_boot_loader_timeout_ctr.sv | 29 ++
 rtl/imem_boot_loader.sv | 150 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame constants,
// FSM state encoding and the word-count validity rule.
package imem_boot_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT   = 8'hA5;
    localparam int         IMEM_WORDS_DEFAULT  = 256;
    localparam int         TIMEOUT_CYC_DEFAULT = 1_000_000;

    // IMEM is word addressed with 8 index bits; the byte address puts them at [9:2]
    localparam int IMEM_ADDR_W = 8;
    // One extra bit so the word index can reach IMEM_WORDS without wrapping
    localparam int WORD_CNT_W  = IMEM_ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    // A frame must carry at least one word and no more than the memory holds
    function automatic logic count_ok(input logic [15:0] n, input logic [15:0] max_n);
        return (n != 16'd0) && (n <= max_n);
    endfunction

endpackage

// File: rtl/imem_boot_loader_timeout_ctr.sv
// Loadable down-counter used as an inter-byte watchdog. Reloads on clear and
// flags expiry once LOAD_VALUE enabled cycles have passed without a clear.
module imem_boot_loader_timeout_ctr #(
    parameter int LOAD_VALUE = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW   = $clog2(LOAD_VALUE + 1);
    localparam logic [CW-1:0]  LOAD = CW'(LOAD_VALUE);

    logic [CW-1:0] remaining;

    // Reload on reset or clear, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            remaining <= LOAD;
        end else if (enable && (remaining != '0)) begin
            remaining <= remaining - CW'(1);
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a framed byte stream from the UART receiver, writes the
// program image into the instruction memory and holds the core in reset until
// a complete frame with a matching checksum has been stored.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int         IMEM_WORDS  = IMEM_WORDS_DEFAULT,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [15:0] MAX_WORDS = 16'(IMEM_WORDS);

    boot_state_t           state;
    logic [7:0]            cnt_lo;
    logic [15:0]           word_cnt;
    logic [7:0]            csum;
    logic [WORD_CNT_W-1:0] word_idx;
    logic [1:0]            byte_idx;
    logic                  in_frame;
    logic                  timed_out;
    logic                  last_word;
    logic [15:0]           rx_count;

    assign in_frame  = (state == ST_CNT_LO) || (state == ST_CNT_HI) ||
                       (state == ST_DATA)   || (state == ST_CSUM);
    assign rx_count  = {rx_data, cnt_lo};
    assign last_word = ({{(16 - WORD_CNT_W){1'b0}}, word_idx} == (word_cnt - 16'd1));

    // The watchdog runs only inside a frame and restarts on every received byte
    imem_boot_loader_timeout_ctr #(
        .LOAD_VALUE (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_frame || rx_valid),
        .enable  (in_frame),
        .expired (timed_out)
    );

    // Frame parser FSM with registered IMEM write port and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            cnt_lo     <= '0;
            word_cnt   <= '0;
            csum       <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                // DONE and ERR last one cycle but still accept a sync so a
                // back-to-back reload is not lost
                ST_IDLE, ST_DONE, ST_ERR: begin
                    state <= ST_IDLE;
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state      <= ST_CNT_LO;
                        core_rst_n <= 1'b0;
                        load_busy  <= 1'b1;
                        load_done  <= 1'b0;
                        load_err   <= 1'b0;
                        csum       <= '0;
                        word_idx   <= '0;
                        byte_idx   <= '0;
                    end
                end
                ST_CNT_LO: begin
                    if (rx_valid) begin
                        cnt_lo <= rx_data;
                        csum   <= csum + rx_data;
                        state  <= ST_CNT_HI;
                    end
                end
                ST_CNT_HI: begin
                    if (rx_valid) begin
                        word_cnt <= rx_count;
                        csum     <= csum + rx_data;
                        if (count_ok(rx_count, MAX_WORDS)) begin
                            state <= ST_DATA;
                        end else begin
                            state     <= ST_ERR;
                            load_err  <= 1'b1;
                            load_busy <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        imem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                        csum     <= csum + rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_addr <= {{(32 - IMEM_ADDR_W - 2){1'b0}},
                                          word_idx[IMEM_ADDR_W-1:0], 2'b00};
                            word_idx  <= word_idx + WORD_CNT_W'(1);
                            if (last_word) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        load_busy <= 1'b0;
                        if (rx_data == csum) begin
                            state      <= ST_DONE;
                            load_done  <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state    <= ST_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A stalled sender aborts the frame; the core stays in reset
            if (in_frame && !rx_valid && timed_out) begin
                state     <= ST_ERR;
                load_err  <= 1'b1;
                load_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table of randomized frames checked
// against a frame-level model, plus hand-written latency, timeout and reset cases.
module tb_imem_boot_loader;

    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string name;
        int    n_words;
        int    count_field;
        int    csum_delta;
        bit    garbage;
        bit    sync_in_data;
        int    max_gap;
        bit    exp_done;
        bit    exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] writes[$];
    logic [31:0] exp_words[$];

    imem_boot_loader #(
        .IMEM_WORDS  (256),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Capture every IMEM write, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we) writes.push_back({imem_addr, imem_wdata});
    end

    // Global watchdog so a stuck DUT still ends the run
    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t make_vec(input string name, input int n, input int cnt,
                                      input int delta, input bit garb, input bit sync_d,
                                      input int gap, input bit done, input bit err);
        vec_t v;
        v.name = name; v.n_words = n; v.count_field = cnt; v.csum_delta = delta;
        v.garbage = garb; v.sync_in_data = sync_d; v.max_gap = gap;
        v.exp_done = done; v.exp_err = err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic gap(input int max_gap);
        idle($urandom_range(0, max_gap));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_we"},    32'(imem_we),    32'd0);
        checkOutput({tag, "_addr"},  imem_addr,       32'd0);
        checkOutput({tag, "_wdata"}, imem_wdata,      32'd0);
        checkOutput({tag, "_core"},  32'(core_rst_n), 32'd0);
        checkOutput({tag, "_busy"},  32'(load_busy),  32'd0);
        checkOutput({tag, "_done"},  32'(load_done),  32'd0);
        checkOutput({tag, "_err"},   32'(load_err),   32'd0);
    endtask

    // Build and send one frame; the model records which words must land in IMEM
    task automatic applyStimulus(input vec_t v);
        int          count;
        logic [7:0]  cs;
        logic [31:0] word;
        count = (v.count_field < 0) ? v.n_words : v.count_field;
        cs = 8'h00;
        exp_words.delete();
        writes.delete();
        if (v.garbage) begin
            send_byte(8'h00); gap(v.max_gap);
            send_byte(8'hFF); gap(v.max_gap);
            send_byte(8'h5A); gap(v.max_gap);
        end
        send_byte(8'hA5);
        idle(1);
        checkOutput({v.name, "_sync_flags"},
                    {28'd0, load_busy, core_rst_n, load_done, load_err}, 32'b1000);
        send_byte(count[7:0]);  cs = cs + count[7:0];  gap(v.max_gap);
        send_byte(count[15:8]); cs = cs + count[15:8];
        if (count < 1 || count > 256) begin
            idle(1);
            checkOutput({v.name, "_err_after_cnt"}, 32'(load_err), 32'd1);
        end else begin
            for (int w = 0; w < count; w++) begin
                word = $urandom;
                if (v.sync_in_data && w == 0) word[7:0] = 8'hA5;
                exp_words.push_back(word);
                for (int k = 0; k < 4; k++) begin
                    gap(v.max_gap);
                    send_byte(word[8*k +: 8]);
                    cs = cs + word[8*k +: 8];
                end
            end
            gap(v.max_gap);
            send_byte(cs + 8'(v.csum_delta));
        end
        idle(3);
    endtask

    task automatic runVector(input vec_t v);
        int bad;
        applyStimulus(v);
        checkOutput({v.name, "_done"}, 32'(load_done),  32'(v.exp_done));
        checkOutput({v.name, "_err"},  32'(load_err),   32'(v.exp_err));
        checkOutput({v.name, "_core"}, 32'(core_rst_n), 32'(v.exp_done));
        checkOutput({v.name, "_busy"}, 32'(load_busy),  32'd0);
        checkOutput({v.name, "_nwrites"}, 32'(writes.size()), 32'(exp_words.size()));
        bad = 0;
        for (int i = 0; i < writes.size() && i < exp_words.size(); i++) begin
            if (writes[i] !== {32'(i * 4), exp_words[i]}) begin
                if (bad == 0)
                    $display("[TB] first bad write %0d: got %h expected %h", i,
                             writes[i], {32'(i * 4), exp_words[i]});
                bad++;
            end
        end
        checkOutput({v.name, "_contents"}, 32'(bad), 32'd0);
        if (v.n_words == 256 && writes.size() > 0)
            checkOutput({v.name, "_last_addr"}, writes[writes.size() - 1][63:32], 32'h3FC);
    endtask

    initial begin
        int waited;

        vecs.push_back(make_vec("one_word",     1,  -1,  0, 0, 0, 3, 1, 0));
        vecs.push_back(make_vec("five_words",   5,  -1,  0, 0, 0, 3, 1, 0));
        vecs.push_back(make_vec("sync_in_data", 3,  -1,  0, 0, 1, 2, 1, 0));
        vecs.push_back(make_vec("garbage",      4,  -1,  0, 1, 0, 3, 1, 0));
        vecs.push_back(make_vec("csum_plus1",   3,  -1,  1, 0, 0, 3, 0, 1));
        vecs.push_back(make_vec("csum_minus1",  2,  -1, -1, 0, 0, 1, 0, 1));
        vecs.push_back(make_vec("count_257",    0, 257,  0, 0, 0, 2, 0, 1));
        vecs.push_back(make_vec("count_0",      0,   0,  0, 0, 0, 2, 0, 1));
        vecs.push_back(make_vec("full_256_b2b", 256, -1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(make_vec("reload",       7,  -1,  0, 0, 0, 3, 1, 0));

        // Reset state
        idle(3);
        checkResetValues("reset");
        rst_n = 1'b1;
        idle(2);

        // Spec example frame with exact write latency
        writes.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h14);
        checkOutput("ex_we_latency", 32'(imem_we), 32'd1);
        checkOutput("ex_addr",       imem_addr,    32'd0);
        checkOutput("ex_wdata",      imem_wdata,   32'h0000_0013);
        idle(1);
        checkOutput("ex_we_pulse",   32'(imem_we),    32'd0);
        checkOutput("ex_done",       32'(load_done),  32'd1);
        checkOutput("ex_core",       32'(core_rst_n), 32'd1);
        checkOutput("ex_nwrites",    32'(writes.size()), 32'd1);

        // Randomized frame table
        foreach (vecs[i]) runVector(vecs[i]);

        // Stall after two data bytes until the watchdog aborts the frame
        writes.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        idle(TIMEOUT - 5);
        checkOutput("to_no_early_err", 32'(load_err), 32'd0);
        waited = 0;
        while (!load_err && waited < 40) begin
            idle(1);
            waited++;
        end
        checkOutput("to_err",     32'(load_err),   32'd1);
        checkOutput("to_core",    32'(core_rst_n), 32'd0);
        checkOutput("to_busy",    32'(load_busy),  32'd0);
        checkOutput("to_nwrites", 32'(writes.size()), 32'd0);
        runVector(vecs[1]);

        // Reset pulse mid-DATA, after one word has been written
        writes.delete();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkResetValues("midreset");
        checkOutput("midreset_nwrites", 32'(writes.size()), 32'd1);
        idle(2);
        runVector(vecs[3]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
